irq_controller: RTL and testbench
=================================

// Module: irq_controller
// PURPOSE
//  Interrupt aggregator sitting directly downstream of systick and the other peripheral irq outputs.
//  Latches per-source requests (systick emits 1-cycle irq pulses) into a pending register and masks them.
//  Drives one level interrupt line to the picoRV32 core. Same 16-byte select/wstrb/addr/data bus slave as the peripherals.
// PARAMETERS
//  NUM_IRQ   8   number of interrupt sources, 1..32; register bits [31:NUM_IRQ] read 0, writes ignored
// PORTS
//  clk       in   1        system clock; the only clock
//  reset_n   in   1        asynchronous, active-low reset
//  select    in   1        bus access request
//  wstrb     in   4        byte write strobes; 0 = read
//  addr      in   4        byte offset; 0x0/0x4/0x8/0xC decoded, other offsets ignored
//  data_i    in   32       write data
//  ready     out  1        registered access acknowledge
//  data_o    out  32       registered read data
//  irq_src   in   NUM_IRQ  raw source lines (bit 0 = systick)
//  cpu_irq   out  1        level interrupt to the core
// BEHAVIOUR
//  Reset (async): ENABLE=0, PENDING=0, MODE=0, src_q=0, ready=0, data_o=0, cpu_irq=0.
//  Registers: 0x0 ENABLE RW | 0x4 PENDING R, write-1-to-clear | 0x8 MODE RW (1=level, 0=rising edge) | 0xC CLAIM R.
//  Handshake: access is performed only in a cycle with select && !ready; ready<=select && !ready.
//   Result: 1-cycle ready pulse, data_o valid in the same cycle. A held select re-accesses every 2nd cycle.
//  Writes honour byte lanes: lane k is written only when wstrb[k]=1. Reads update data_o; writes leave it unchanged.
//  Edge capture: src_q <= irq_src every cycle.
//   Edge bit i: set_i = irq_src[i] & ~src_q[i]. Level bit i: set_i = irq_src[i].
//   pending_next = (PENDING & ~clr) | set. Set wins over a same-cycle W1C clear or claim.
//  A source is captured into PENDING regardless of ENABLE. ENABLE only masks cpu_irq and CLAIM.
//  cpu_irq <= |(PENDING & ENABLE), registered: one cycle after the PENDING/ENABLE change.
//   Latency from a systick irq pulse to cpu_irq=1 is 2 cycles.
//  Level-mode bit with its source still high: a W1C clear is immediately re-set (set wins). Clearing the source is software's job.
//  MODE change from level to edge: no spurious set, because src_q is always tracking.
//  Writes to PENDING only clear bits; writing 0 has no effect. Software cannot set PENDING.
//  Reset mid-access: ready and data_o return to 0 immediately. The access is dropped; the master must retry.
// CONFIGURATION
//  IRQC_CLAIM_EN defined:
//   CLAIM read returns {valid, 26'b0, id[4:0]} for the lowest-index bit of PENDING & ENABLE.
//   The same access clears that PENDING bit, unless a set for it occurs that cycle.
//   Returns 0 (valid=0) when nothing is pending.
//  IRQC_CLAIM_EN undefined: CLAIM reads 32'h0 with no side effect; the priority encoder is not built.
// STRUCTURE
//  irqc_defs.vh: register offsets IRQC_OFF_ENABLE/PENDING/MODE/CLAIM and the CLAIM valid-bit position.
//  Sub-module irqc_prio_enc: combinational lowest-index encoder, NUM_IRQ-wide in, valid + 5-bit id out.
//   Instantiated only under IRQC_CLAIM_EN.
//  Top holds the bus FSM (IDLE/ACK via the ready flop), edge detectors, registers and the cpu_irq flop.
// TESTING
//  1 Reset then read 0x0,0x4,0x8,0xC -> all 0; ready pulses 1 cycle after each select; cpu_irq=0.
//  2 ENABLE=0x1, 1-cycle pulse on irq_src[0] -> PENDING=0x1, cpu_irq=1 two cycles after pulse.
//    Then write 0x1 to 0x4 -> PENDING=0, cpu_irq=0 one cycle later.
//  3 irq_src[3] held high with MODE=0 -> PENDING[3] set once. After a W1C clear it stays 0.
//    Same with MODE[3]=1 -> PENDING[3] re-sets immediately.
//  4 A W1C of bit 0 in the same cycle as a new irq_src[0] edge -> PENDING[0]=1 (set wins).
//  5 IRQC_CLAIM_EN, ENABLE=0xFF, PENDING=0x28 -> CLAIM reads 0x80000003, then 0x80000005, then 0x0.
//    Without the macro -> CLAIM reads 0 and PENDING stays 0x28.
//  6 select held high for 6 cycles -> exactly 3 ready pulses; wstrb=4'b0001 write of 0xFFFFFFFF to ENABLE -> reads 0x000000FF.
//    Assert reset_n low mid-access -> ready=0 and data_o=0 at once.

Source files
------------

// File: rtl/irq_controller_pkg.sv
// irq_controller_pkg
//   Shared definitions for the interrupt controller: register byte offsets,
//   the bit position of the CLAIM valid flag and the bus FSM state type.
package irq_controller_pkg;

  localparam logic [3:0] IRQC_OFF_ENABLE  = 4'h0;
  localparam logic [3:0] IRQC_OFF_PENDING = 4'h4;
  localparam logic [3:0] IRQC_OFF_MODE    = 4'h8;
  localparam logic [3:0] IRQC_OFF_CLAIM   = 4'hC;

  localparam int IRQC_CLAIM_VALID_BIT = 31;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_ACK  = 1'b1
  } bus_state_e;

endpackage

// File: rtl/irq_controller_if.sv
// irq_controller_if
//   Peripheral register bus: select/wstrb/addr/data_i from the master,
//   registered ready/data_o back from the slave.
//   select  1   access request
//   wstrb   4   byte write strobes, 0 = read
//   addr    4   byte offset
//   data_i  32  write data
//   ready   1   one-cycle access acknowledge
//   data_o  32  read data, valid with ready
interface irq_controller_if;
  logic        select;
  logic [3:0]  wstrb;
  logic [3:0]  addr;
  logic [31:0] data_i;
  logic        ready;
  logic [31:0] data_o;

  modport master (output select, output wstrb, output addr, output data_i,
                  input ready, input data_o);
  modport slave  (input select, input wstrb, input addr, input data_i,
                  output ready, output data_o);
endinterface

// File: rtl/irqc_prio_enc.sv
// irqc_prio_enc
//   Combinational lowest-index priority encoder.
//   req    NUM_IRQ  request vector
//   valid  1        any request set
//   id     5        index of the lowest set request (0 when none)
module irqc_prio_enc #(
  parameter int NUM_IRQ = 8
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [4:0]         id
);

  // Scan from the top down so the lowest set index is the last one written.
  always_comb begin
    valid = 1'b0;
    id    = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        id    = 5'(i);
      end
    end
  end

endmodule

// File: rtl/irq_controller.sv
// irq_controller
//   Latches per-source interrupt requests into PENDING (edge or level per
//   MODE bit), masks them with ENABLE and drives one level interrupt line.
//   Registers: 0x0 ENABLE RW, 0x4 PENDING R/W1C, 0x8 MODE RW (1=level),
//   0xC CLAIM R.
//   Build option: IRQC_CLAIM_EN builds the claim priority encoder; without
//   it CLAIM reads 0 with no side effect.
//   clk      system clock
//   reset_n  asynchronous active-low reset
//   bus      register bus slave port
//   irq_src  raw interrupt source lines (bit 0 = systick)
//   cpu_irq  registered level interrupt to the core
//
//   state   | meaning
//   IDLE    | ready low, an asserted select is accepted this cycle
//   ACK     | ready high for one cycle, select ignored
module irq_controller
  import irq_controller_pkg::*;
#(
  parameter int NUM_IRQ = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  irq_controller_if.slave    bus,
  input  logic [NUM_IRQ-1:0] irq_src,
  output logic               cpu_irq
);

  bus_state_e state_q, state_d;

  logic               access, is_write, is_read;
  logic [NUM_IRQ-1:0] wmask, wdata;
  logic [NUM_IRQ-1:0] enable_q, pending_q, mode_q, src_q;
  logic [NUM_IRQ-1:0] set, w1c, claim_clr, pending_d;
  logic [31:0]        rd_word, claim_word;
  logic               unused_bus;

  // Upper data/strobe bits are meaningless when NUM_IRQ < 32.
  assign unused_bus = ^{bus.data_i, bus.wstrb};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (state_q == ST_IDLE && bus.select) state_d = ST_ACK;
  end

  assign bus.ready = (state_q == ST_ACK);
  assign access    = bus.select && (state_q == ST_IDLE);
  assign is_write  = access && (bus.wstrb != 4'b0000);
  assign is_read   = access && (bus.wstrb == 4'b0000);

  always_comb begin
    wmask = '0;
    for (int i = 0; i < NUM_IRQ; i++) wmask[i] = bus.wstrb[i / 8];
  end
  assign wdata = bus.data_i[NUM_IRQ-1:0];

`ifdef IRQC_CLAIM_EN
  logic       claim_valid;
  logic [4:0] claim_id;

  irqc_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio_enc (
    .req   (pending_q & enable_q),
    .valid (claim_valid),
    .id    (claim_id)
  );

  always_comb begin
    claim_word = 32'(claim_id);
    claim_word[IRQC_CLAIM_VALID_BIT] = claim_valid;
    claim_clr = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      claim_clr[i] = is_read && (bus.addr == IRQC_OFF_CLAIM) && claim_valid && (claim_id == 5'(i));
  end
`else
  assign claim_word = '0;
  assign claim_clr  = '0;
`endif

  // src_q always tracks, so a level->edge MODE change cannot create a set.
  assign set = irq_src & (mode_q | ~src_q);
  assign w1c = (is_write && bus.addr == IRQC_OFF_PENDING) ? (wdata & wmask) : '0;
  // A same-cycle set overrides any clear.
  assign pending_d = (pending_q & ~(w1c | claim_clr)) | set;

  always_comb begin
    rd_word = '0;
    case (bus.addr)
      IRQC_OFF_ENABLE:  rd_word[NUM_IRQ-1:0] = enable_q;
      IRQC_OFF_PENDING: rd_word[NUM_IRQ-1:0] = pending_q;
      IRQC_OFF_MODE:    rd_word[NUM_IRQ-1:0] = mode_q;
      IRQC_OFF_CLAIM:   rd_word = claim_word;
      default:          rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      enable_q   <= '0;
      pending_q  <= '0;
      mode_q     <= '0;
      src_q      <= '0;
      cpu_irq    <= 1'b0;
      bus.data_o <= '0;
    end else begin
      src_q     <= irq_src;
      pending_q <= pending_d;
      cpu_irq   <= |(pending_q & enable_q);
      if (is_write && bus.addr == IRQC_OFF_ENABLE)
        enable_q <= (enable_q & ~wmask) | (wdata & wmask);
      if (is_write && bus.addr == IRQC_OFF_MODE)
        mode_q <= (mode_q & ~wmask) | (wdata & wmask);
      if (is_read)
        bus.data_o <= rd_word;
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
module tb_irq_controller;
  localparam int NUM_IRQ = 8;

  logic               clk = 1'b0;
  logic               reset_n = 1'b0;
  logic [NUM_IRQ-1:0] irq_src = '0;
  logic               cpu_irq;

  irq_controller_if bus ();

  irq_controller #(.NUM_IRQ(NUM_IRQ)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus),
    .irq_src (irq_src),
    .cpu_irq (cpu_irq)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: registers as plain words, behaviour from the register rules.
  logic [31:0] m_en, m_pend, m_mode, m_src, m_data;
  bit          m_ready, m_cpu;
  logic [31:0] reg_mask;

  function automatic logic [31:0] lanes(input logic [3:0] ws);
    logic [31:0] m;
    m = '0;
    for (int k = 0; k < 4; k++) if (ws[k]) m |= 32'hFF << (8 * k);
    return m;
  endfunction

  task automatic model_reset();
    m_en = 0; m_pend = 0; m_mode = 0; m_src = 0; m_data = 0;
    m_ready = 0; m_cpu = 0;
  endtask

  // Called at posedge+#1; applies one cycle of inputs and checks the result.
  task automatic cycle(input bit sel, input logic [3:0] ws, input logic [3:0] ad,
                       input logic [31:0] wd, input logic [NUM_IRQ-1:0] src);
    logic [31:0] set, clr, src32, n_en, n_mode, n_data, act;
    bit acc;
    bus.select = sel; bus.wstrb = ws; bus.addr = ad; bus.data_i = wd;
    irq_src = src;
    src32 = 32'(src);
    set = 0;
    for (int i = 0; i < NUM_IRQ; i++)
      set[i] = m_mode[i] ? src32[i] : (src32[i] && !m_src[i]);
    clr = 0; n_en = m_en; n_mode = m_mode; n_data = m_data;
    acc = sel && !m_ready;
    if (acc && ws != 0) begin
      if (ad == 4'h0) n_en = ((m_en & ~lanes(ws)) | (wd & lanes(ws))) & reg_mask;
      if (ad == 4'h4) clr = wd & lanes(ws) & reg_mask;
      if (ad == 4'h8) n_mode = ((m_mode & ~lanes(ws)) | (wd & lanes(ws))) & reg_mask;
    end else if (acc) begin
      case (ad)
        4'h0: n_data = m_en;
        4'h4: n_data = m_pend;
        4'h8: n_data = m_mode;
        4'hC: begin
          n_data = 0;
`ifdef IRQC_CLAIM_EN
          act = m_pend & m_en;
          for (int i = NUM_IRQ - 1; i >= 0; i--)
            if (act[i]) n_data = 32'h8000_0000 + 32'(i);
          if (n_data != 0) clr[n_data[4:0]] = 1'b1;
`endif
        end
        default: n_data = 0;
      endcase
    end
    m_cpu  = (m_pend & m_en) != 0;
    m_pend = ((m_pend & ~clr) | set) & reg_mask;
    m_en = n_en; m_mode = n_mode; m_data = n_data; m_src = src32;
    m_ready = acc;
    @(posedge clk); #1;
    check("ready", 32'(bus.ready), 32'(m_ready));
    check("data_o", bus.data_o, m_data);
    check("cpu_irq", 32'(cpu_irq), 32'(m_cpu));
  endtask

  task automatic idle(input logic [NUM_IRQ-1:0] src);
    cycle(1'b0, 4'h0, 4'h0, 32'h0, src);
  endtask

  logic [3:0] addr_tab [5] = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h2};

  initial begin
    int cnt;
    logic [NUM_IRQ-1:0] src;
    reg_mask = (NUM_IRQ == 32) ? 32'hFFFF_FFFF : ((32'h1 << NUM_IRQ) - 1);
    bus.select = 0; bus.wstrb = 0; bus.addr = 0; bus.data_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.ready), 32'h0);
    check("rst_data_o", bus.data_o, 32'h0);
    check("rst_cpu_irq", 32'(cpu_irq), 32'h0);
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Reads after reset
    for (int a = 0; a < 4; a++) begin
      cycle(1'b1, 4'h0, addr_tab[a], 32'h0, '0);
      idle('0);
    end

    // Claim ordering with PENDING=0x28
    cycle(1'b1, 4'hF, 4'h0, 32'hFF, '0); idle('0);
    idle(8'h28); idle('0); idle('0);
    cycle(1'b1, 4'h0, 4'hC, 0, '0); idle('0);
`ifdef IRQC_CLAIM_EN
    check("claim_1", bus.data_o, 32'h8000_0003);
    cycle(1'b1, 4'h0, 4'hC, 0, '0); idle('0);
    check("claim_2", bus.data_o, 32'h8000_0005);
    cycle(1'b1, 4'h0, 4'hC, 0, '0); idle('0);
    check("claim_3", bus.data_o, 32'h0);
`else
    check("claim_off", bus.data_o, 32'h0);
    cycle(1'b1, 4'h0, 4'h4, 0, '0); idle('0);
    check("pend_kept", bus.data_o, 32'h28);
    cycle(1'b1, 4'hF, 4'h4, 32'h28, '0); idle('0);
`endif

    // Set wins over a same-cycle W1C of bit 0
    idle('0);
    cycle(1'b1, 4'hF, 4'h4, 32'h1, 8'h01);
    idle('0);
    cycle(1'b1, 4'h0, 4'h4, 0, '0); idle('0);
    check("set_wins", 32'(bus.data_o[0]), 32'h1);

    // Held select: 3 pulses in 6 cycles; byte-lane write to ENABLE
    cnt = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1'b1, (c == 0) ? 4'b0001 : 4'b0000, 4'h0, 32'hFFFF_FFFF, '0);
      if (bus.ready) cnt++;
    end
    idle('0);
    check("held_sel_pulses", 32'(cnt), 32'h3);
    check("lane_write", bus.data_o, 32'h0000_00FF);

    // Randomized traffic
    src = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NUM_IRQ; i++)
        if ($urandom_range(0, 7) == 0) src[i] = ~src[i];
      cycle(1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom),
            addr_tab[$urandom_range(0, 4)], $urandom, src);
    end

    // Reset in the middle of an access
    idle('0); idle('0);
    cycle(1'b1, 4'hF, 4'h0, 32'hA5, '0); idle('0);
    cycle(1'b1, 4'h0, 4'h0, 0, '0);
    check("pre_rst_data_o", bus.data_o, 32'hA5);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_ready", 32'(bus.ready), 32'h0);
    check("mid_rst_data_o", bus.data_o, 32'h0);
    check("mid_rst_cpu_irq", 32'(cpu_irq), 32'h0);
    model_reset();
    bus.select = 0;
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    cycle(1'b1, 4'h0, 4'h0, 0, '0); idle('0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
